register_file_sb: RTL and testbench

- Parametrised multi-read-port register file with a per-register pending scoreboard, write-to-read bypass and optional hardwired zero register.
- Successor to the fixed 64x64, two-read-port register file.
- Sits in the pipeline's decode/writeback path:
  - Decode reads operands and reserves destination registers.
  - Writeback writes results and clears the reservations.

---
 rtl/register_file_sb.sv | 93 +++++++++
 tb/tb_register_file_sb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// Parametrised multi-read-port register file with a per-register pending scoreboard,
// same-cycle write-to-read bypass and an optional hardwired zero register.
module register_file_sb #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_READ   = 2,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] readAdr,
  output logic [NUM_READ*DATA_WIDTH-1:0] readData,
  output logic [NUM_READ-1:0]            readPending,
  input  logic                           writeEnable,
  input  logic [ADDR_WIDTH-1:0]          writeAdr,
  input  logic [DATA_WIDTH-1:0]          writeData,
  input  logic                           reserveEnable,
  input  logic [ADDR_WIDTH-1:0]          reserveAdr,
  output logic                           errorSticky,
  input  logic                           errorClear
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] mem_d [Depth];
  logic [Depth-1:0]      pending_q, pending_d;
  logic                  error_q, error_d;

  logic                  wr_eff, rsv_eff;
  logic [ADDR_WIDTH-1:0] rd_adr [NUM_READ];

  // Accesses to the zero register are dropped before they reach any state.
  assign wr_eff  = writeEnable && !(ZERO_REG && (writeAdr == '0));
  assign rsv_eff = reserveEnable && !(ZERO_REG && (reserveAdr == '0));

  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    error_d   = error_q;
    if (wr_eff) begin
      mem_d[writeAdr]     = writeData;
      pending_d[writeAdr] = 1'b0;
    end
    // Applied after the write clear so a same-address reserve wins.
    if (rsv_eff) begin
      pending_d[reserveAdr] = 1'b1;
    end
    if (errorClear) begin
      error_d = 1'b0;
    end
    if (wr_eff && !pending_q[writeAdr]) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      pending_q <= '0;
      error_q   <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    readData    = '0;
    readPending = '0;
    for (int unsigned i = 0; i < NUM_READ; i++) begin
      rd_adr[i] = readAdr[i*ADDR_WIDTH +: ADDR_WIDTH];
      readData[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_adr[i]];
      readPending[i] = pending_q[rd_adr[i]];
      if (BYPASS && writeEnable && (writeAdr == rd_adr[i])) begin
        readData[i*DATA_WIDTH +: DATA_WIDTH] = writeData;
        readPending[i] = 1'b0;
      end
      // Zero register masks bypass too, since raw writeEnable feeds the bypass.
      if (ZERO_REG && (rd_adr[i] == '0)) begin
        readData[i*DATA_WIDTH +: DATA_WIDTH] = '0;
        readPending[i] = 1'b0;
      end
    end
  end

  assign errorSticky = error_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: one bypassing and one non-bypassing instance
// share stimulus; expected values are queued by the driver and popped by a monitor.
module tb_register_file_sb;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 6;
  localparam int unsigned NR = 2;

  logic              clk = 1'b0;
  logic              resetN;
  logic [NR*AW-1:0]  readAdr;
  logic [NR*DW-1:0]  rd_data0, rd_data1;
  logic [NR-1:0]     rd_pend0, rd_pend1;
  logic              writeEnable;
  logic [AW-1:0]     writeAdr;
  logic [DW-1:0]     writeData;
  logic              reserveEnable;
  logic [AW-1:0]     reserveAdr;
  logic              err0, err1;
  logic              errorClear;

  always #5 clk = ~clk;

  register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1'b1),
                     .BYPASS(1'b1)) u_byp (
    .clk(clk), .resetN(resetN), .readAdr(readAdr), .readData(rd_data0),
    .readPending(rd_pend0), .writeEnable(writeEnable), .writeAdr(writeAdr),
    .writeData(writeData), .reserveEnable(reserveEnable), .reserveAdr(reserveAdr),
    .errorSticky(err0), .errorClear(errorClear)
  );

  register_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1'b1),
                     .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .resetN(resetN), .readAdr(readAdr), .readData(rd_data1),
    .readPending(rd_pend1), .writeEnable(writeEnable), .writeAdr(writeAdr),
    .writeData(writeData), .reserveEnable(reserveEnable), .reserveAdr(reserveAdr),
    .errorSticky(err1), .errorClear(errorClear)
  );

  // kind: 0 = read data, 1 = read pending, 2 = error flag
  typedef struct {
    string       name;
    int          dut;
    int          kind;
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] observe(input exp_t e);
    logic [63:0] v;
    v = '0;
    case (e.kind)
      0: v = (e.dut == 0) ? rd_data0[e.port*DW +: DW] : rd_data1[e.port*DW +: DW];
      1: v = {63'd0, (e.dut == 0) ? rd_pend0[e.port] : rd_pend1[e.port]};
      default: v = {63'd0, (e.dut == 0) ? err0 : err1};
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e   = sb.pop_front();
      act = observe(e);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s dut%0d kind%0d port%0d: got %h expected %h",
                 e.name, e.dut, e.kind, e.port, act, e.exp);
      end
    end
  end

  task automatic exp_port(input string name, input int dut, input int port,
                          input logic [63:0] data, input logic pend);
    exp_t e;
    e.name = name; e.dut = dut; e.port = port;
    e.kind = 0; e.exp = data;          sb.push_back(e);
    e.kind = 1; e.exp = {63'd0, pend}; sb.push_back(e);
  endtask

  task automatic exp_err(input string name, input int dut, input logic v);
    exp_t e;
    e.name = name; e.dut = dut; e.port = 0; e.kind = 2; e.exp = {63'd0, v};
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input logic ec,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    writeEnable   = we;
    writeAdr      = wa;
    writeData     = wd;
    reserveEnable = re;
    reserveAdr    = ra;
    errorClear    = ec;
    readAdr       = {a1, a0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetN = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 6'd5, 6'd5);

    step();
    exp_port("reset_init", 0, 0, 64'h0, 1'b0);
    exp_err("reset_init_err", 0, 1'b0);

    step(); resetN = 1'b1; drive(0, 0, 0, 1, 6'd5, 0, 6'd5, 6'd5);
    step(); drive(1, 6'd5, 64'hDEAD, 0, 0, 0, 6'd5, 6'd5);
    step(); drive(0, 0, 0, 0, 0, 0, 6'd5, 6'd5);
    exp_port("pre_reset_dead", 0, 0, 64'hDEAD, 1'b0);
    step(); resetN = 1'b0;
    #1;
    checks++;
    if (rd_data0[DW-1:0] !== 64'h0 || rd_pend0[0] !== 1'b0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_direct: data %h pend %b err %b",
               rd_data0[DW-1:0], rd_pend0[0], err0);
    end
    exp_port("async_reset", 0, 0, 64'h0, 1'b0);
    exp_port("async_reset", 1, 1, 64'h0, 1'b0);
    exp_err("async_reset_err", 0, 1'b0);

    // Reserve then write register 7
    step(); resetN = 1'b1;
    step(); drive(0, 0, 0, 1, 6'd7, 0, 6'd7, 6'd7);
    exp_port("rsv7_same_cycle", 0, 0, 64'h0, 1'b0);
    step(); drive(0, 0, 0, 0, 0, 0, 6'd7, 6'd7);
    exp_port("rsv7_pending", 0, 0, 64'h0, 1'b1);
    exp_port("rsv7_pending", 1, 1, 64'h0, 1'b1);
    step(); drive(1, 6'd7, 64'h1234, 0, 0, 0, 6'd7, 6'd7);
    exp_port("wr7_bypass", 0, 0, 64'h1234, 1'b0);
    exp_port("wr7_nobypass", 1, 0, 64'h0, 1'b1);
    step(); drive(0, 0, 0, 0, 0, 0, 6'd7, 6'd7);
    #1;
    checks++;
    if (rd_data1[DW-1:0] !== 64'h1234 || rd_pend1[0] !== 1'b0) begin
      errors++;
      $display("FAIL wr7_direct: data %h pend %b", rd_data1[DW-1:0], rd_pend1[0]);
    end
    exp_port("wr7_after", 0, 0, 64'h1234, 1'b0);
    exp_port("wr7_after", 1, 0, 64'h1234, 1'b0);
    exp_err("wr7_err", 0, 1'b0);

    // Bypass on both ports
    step(); drive(0, 0, 0, 1, 6'd3, 0, 6'd3, 6'd3);
    step(); drive(1, 6'd3, 64'hABCD, 0, 0, 0, 6'd3, 6'd3);
    exp_port("byp3_p0", 0, 0, 64'hABCD, 1'b0);
    exp_port("byp3_p1", 0, 1, 64'hABCD, 1'b0);
    exp_port("nobyp3_p0", 1, 0, 64'h0, 1'b1);
    exp_port("nobyp3_p1", 1, 1, 64'h0, 1'b1);
    step(); drive(0, 0, 0, 0, 0, 0, 6'd7, 6'd3);
    exp_port("multi_p0", 0, 0, 64'h1234, 1'b0);
    exp_port("multi_p1", 0, 1, 64'hABCD, 1'b0);
    exp_port("multi_p0", 1, 0, 64'h1234, 1'b0);
    exp_port("multi_p1", 1, 1, 64'hABCD, 1'b0);

    // Reserve + write collision on register 9 (already pending)
    step(); drive(0, 0, 0, 1, 6'd9, 0, 6'd9, 6'd9);
    step(); drive(1, 6'd9, 64'h55, 1, 6'd9, 0, 6'd9, 6'd9);
    exp_port("coll9_nobyp", 1, 0, 64'h0, 1'b1);
    step(); drive(0, 0, 0, 0, 0, 0, 6'd9, 6'd9);
    exp_port("coll9_after", 0, 0, 64'h55, 1'b1);
    exp_port("coll9_after", 1, 1, 64'h55, 1'b1);
    exp_err("coll9_err", 0, 1'b0);

    // Zero register
    step(); drive(0, 0, 0, 1, 6'd0, 0, 6'd0, 6'd0);
    step(); drive(1, 6'd0, 64'hFF, 0, 0, 0, 6'd0, 6'd0);
    exp_port("zero_rsv", 0, 0, 64'h0, 1'b0);
    exp_port("zero_wr_byp", 0, 1, 64'h0, 1'b0);
    exp_port("zero_wr_nobyp", 1, 0, 64'h0, 1'b0);
    step(); drive(0, 0, 0, 0, 0, 0, 6'd0, 6'd0);
    exp_port("zero_after", 0, 0, 64'h0, 1'b0);
    exp_err("zero_err", 0, 1'b0);
    exp_err("zero_err", 1, 1'b0);

    // Sticky error: set, clear, set-wins-over-clear
    step(); drive(1, 6'd12, 64'h77, 0, 0, 0, 6'd12, 6'd12);
    exp_port("err12_byp", 0, 0, 64'h77, 1'b0);
    exp_err("err12_pre", 0, 1'b0);
    step(); drive(0, 0, 0, 0, 0, 0, 6'd12, 6'd12);
    exp_err("err12_set", 0, 1'b1);
    exp_err("err12_set", 1, 1'b1);
    exp_port("err12_data", 1, 0, 64'h77, 1'b0);
    step(); drive(0, 0, 0, 0, 0, 1, 6'd12, 6'd12);
    exp_err("clr_same_cycle", 0, 1'b1);
    step(); drive(0, 0, 0, 0, 0, 0, 6'd12, 6'd12);
    exp_err("clr_done", 0, 1'b0);
    exp_err("clr_done", 1, 1'b0);
    step(); drive(1, 6'd13, 64'h1, 0, 0, 1, 6'd13, 6'd13);
    step(); drive(0, 0, 0, 0, 0, 0, 6'd13, 6'd13);
    #1;
    checks++;
    if (err0 !== 1'b1 || err1 !== 1'b1) begin
      errors++;
      $display("FAIL set_wins_direct: err0 %b err1 %b", err0, err1);
    end
    exp_err("set_wins", 0, 1'b1);
    exp_err("set_wins", 1, 1'b1);

    step();
    @(negedge clk);
    #1;
    if (errors != 0) begin
      $display("FAIL");
    end else begin
      $display("PASS");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
